// File: rtl/drum_env_pkg.sv
// drum_env_pkg: shared types for the drum-envelope table writer and player.
package drum_env_pkg;

   localparam int ENV_FREQ_BITS = 8;
   localparam int ENV_VOL_BITS  = 8;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_DONE} env_state_t;

   typedef struct packed {
      logic [ENV_FREQ_BITS-1:0] freq;
      logic [ENV_VOL_BITS-1:0]  vol;
   } env_entry_t;

endpackage

// File: rtl/env_step_timer.sv
// env_step_timer: per-entry hold counter; terminal count fires on the last hold cycle.
module env_step_timer #(
   parameter int DIV_BITS = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                en_i,
   input  logic [DIV_BITS-1:0] limit_i,
   output logic                tc_o
);

   logic [DIV_BITS-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt_q <= '0;
      else if (load_i) cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + 1'b1;

   // limit_i is never 0 while counting, so limit-1 keeps the counter from wrapping
   assign tc_o = cnt_q == limit_i - 1'b1;

endmodule

// File: rtl/envelope_table_player.sv
// envelope_table_player: plays a {freq, vol} envelope table out of BRAM after a trigger,
// holding each entry for a programmable number of clocks.
module envelope_table_player
   import drum_env_pkg::*;
#(
   parameter int ADDR_BITS     = 6,
   parameter int FREQ_RES_BITS = ENV_FREQ_BITS,
   parameter int VOLUME_BITS   = ENV_VOL_BITS,
   parameter int DIV_BITS      = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 trig,
   input  logic [ADDR_BITS:0]                   table_len,
   input  logic [DIV_BITS-1:0]                  step_div,
   output logic                                 rd_en,
   output logic [ADDR_BITS-1:0]                 rd_addr,
   input  logic [FREQ_RES_BITS+VOLUME_BITS-1:0] rd_data,
   output logic [FREQ_RES_BITS-1:0]             freq_out,
   output logic [VOLUME_BITS-1:0]               vol_out,
   output logic                                 active,
   output logic                                 done
);

   env_state_t               state_q;
   logic [ADDR_BITS-1:0]     idx_q;
   logic [ADDR_BITS:0]       len_q;
   logic [DIV_BITS-1:0]      div_q;
   logic [FREQ_RES_BITS-1:0] freq_q;
   logic [VOLUME_BITS-1:0]   vol_q;
   logic                     done_q;
   logic                     hold_tc;
   logic                     last;

   assign last = {1'b0, idx_q} == len_q - 1'b1;

   env_step_timer #(.DIV_BITS(DIV_BITS)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .load_i  (state_q == S_LOAD),
      .en_i    (state_q == S_HOLD),
      .limit_i (div_q),
      .tc_o    (hold_tc)
   );

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         div_q   <= '0;
         freq_q  <= '0;
         vol_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // trig wins over everything; an aborted run keeps its outputs until entry 0 loads
         if (trig) begin
            len_q   <= table_len;
            div_q   <= (step_div == '0) ? DIV_BITS'(1) : step_div;
            idx_q   <= '0;
            state_q <= (table_len == '0) ? S_DONE : S_FETCH;
            if (table_len == '0) begin
               vol_q  <= '0;
               done_q <= 1'b1;
            end
         end else begin
            case (state_q)
               S_FETCH: state_q <= S_LOAD;
               S_LOAD: begin
                  {freq_q, vol_q} <= rd_data;
                  state_q         <= S_HOLD;
               end
               S_HOLD:
                  if (hold_tc) begin
                     state_q <= last ? S_DONE : S_FETCH;
                     if (last) begin
                        vol_q  <= '0;
                        done_q <= 1'b1;
                     end else idx_q <= idx_q + 1'b1;
                  end
               default: state_q <= S_IDLE;
            endcase
         end
      end

   assign rd_en    = state_q == S_FETCH;
   assign rd_addr  = idx_q;
   assign active   = state_q inside {S_FETCH, S_LOAD, S_HOLD};
   assign freq_out = freq_q;
   assign vol_out  = vol_q;
   assign done     = done_q;

endmodule
